mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arb_timer.sv | 25 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic PORT_I      = 1'b0;
  localparam logic PORT_D      = 1'b1;
  localparam int   TIMEOUT_DEF = 255;

  // Round-robin choice: on a tie the port not granted last wins.
  function automatic logic rr_pick(input logic i_req, input logic d_req, input logic last);
    if (i_req && d_req) return ~last;
    return d_req ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and backing-memory signals.
// slave = arbiter view, master = surrounding core/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [DATA_W-1:0] i_rdata_o;
  logic              i_ack_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              err_o;
  logic              stall_o;

  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
    output i_rdata_o, i_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, err_o, stall_o
  );

  modport master (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i, mem_ack_i,
    input  i_rdata_o, i_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o, mem_addr_o,
           mem_wdata_o, err_o, stall_o
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT.
module mem_arb_timer import mem_arbiter_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  // Count wait cycles; clear has priority so a new grant starts from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  end

  // Fires during the TIMEOUT-th wait cycle, so the request is dropped after it.
  assign expired = enable && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single backing memory.
// One transaction at a time: grant, wait for memory (or timeout), one-cycle ack.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  state_t            state_q, state_d;
  logic              last_q;      // port of the latest grant, i.e. the port being served
  logic              grant, gport, done_ok, done_err;
  logic              wait_st, expired, resp, i_ack, d_ack;
  logic              req_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;

  assign wait_st = (state_q == I_WAIT) || (state_q == D_WAIT);
  assign resp    = (state_q == RESP);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (grant),
    .enable  (wait_st),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus grant/completion strobes; a memory ack beats a timeout.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    gport    = PORT_I;
    done_ok  = 1'b0;
    done_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req_i || bus.d_req_i) begin
          grant   = 1'b1;
          gport   = rr_pick(bus.i_req_i, bus.d_req_i, last_q);
          state_d = (gport == PORT_D) ? D_WAIT : I_WAIT;
        end
      end
      I_WAIT, D_WAIT: begin
        if (bus.mem_ack_i) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (expired) begin
          done_err = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch request attributes at grant, capture read data / error at completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q    <= PORT_I;        // so the data port wins the first tie
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (grant) begin
      last_q <= gport;
      req_q  <= 1'b1;
      err_q  <= 1'b0;
      if (gport == PORT_D) begin
        we_q    <= bus.d_we_i;
        addr_q  <= bus.d_addr_i;
        wdata_q <= bus.d_wdata_i;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= bus.i_addr_i;
        wdata_q <= '0;
      end
    end else if (done_ok || done_err) begin
      req_q <= 1'b0;
      err_q <= done_err;
      // Stores never touch d_rdata; an aborted read returns zero.
      if (last_q == PORT_I)
        i_rdata_q <= done_ok ? bus.mem_rdata_i : '0;
      else if (!we_q)
        d_rdata_q <= done_ok ? bus.mem_rdata_i : '0;
    end
  end

  assign i_ack = resp && (last_q == PORT_I);
  assign d_ack = resp && (last_q == PORT_D);

  assign bus.i_ack_o     = i_ack;
  assign bus.d_ack_o     = d_ack;
  assign bus.i_rdata_o   = i_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.err_o       = resp && err_q;
  // Forced low in reset so every output reads zero while rst_i is high.
  assign bus.stall_o     = ~rst_i & ((bus.i_req_i & ~i_ack) | (bus.d_req_i & ~d_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-timeline model.
module tb_mem_arbiter;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Requesters (index 0 = fetch, 1 = data)
  logic        rq [2];
  logic [31:0] ra [2];
  logic        rwe;
  logic [31:0] rwd;
  bit          infl [2];
  // In-flight transaction timeline: grant cycle g, memory latency L,
  // W cycles with mem_req high, ack cycle a.
  bit          busy, perr;
  int          gp, last, g, L, W, a;
  logic [31:0] cap;
  // Expected registered outputs
  logic [31:0] m_rd [2];
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  // Stimulus knobs
  int          p_req, p_drop, p_spur, force_l;
  bit          use_rd;
  logic [31:0] rd_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    bus.i_req_i   = rq[0];
    bus.i_addr_i  = ra[0];
    bus.d_req_i   = rq[1];
    bus.d_addr_i  = ra[1];
    bus.d_we_i    = rwe;
    bus.d_wdata_i = rwd;
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; infl[p] = 1'b0; m_rd[p] = '0; ra[p] = '0;
    end
    rwe = 1'b0; rwd = '0; busy = 1'b0; perr = 1'b0; last = 0; gp = 0;
    g = 0; L = 0; W = 0; a = -10; cap = '0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    drive();
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_mem_req"}, bus.mem_req_o, 32'd0);
    chk({pfx, "_i_ack"},   bus.i_ack_o,   32'd0);
    chk({pfx, "_d_ack"},   bus.d_ack_o,   32'd0);
    chk({pfx, "_err"},     bus.err_o,     32'd0);
    chk({pfx, "_stall"},   bus.stall_o,   32'd0);
    chk({pfx, "_mem_we"},  bus.mem_we_o,  32'd0);
    chk({pfx, "_mem_addr"},bus.mem_addr_o,32'd0);
    chk({pfx, "_i_rdata"}, bus.i_rdata_o, 32'd0);
    chk({pfx, "_d_rdata"}, bus.d_rdata_o, 32'd0);
  endtask

  // Async reset pulse away from the clock edge; optionally check outputs clear at once.
  task automatic do_reset(input bit check);
    @(posedge clk); #3; rst = 1'b1; #1;
    if (check) check_zero("rst");
    model_reset();
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
  endtask

  // One clock cycle: drive requesters and memory, predict, compare at negedge.
  task automatic step();
    logic e_req, e_iack, e_dack, e_err, e_stall, e_we, ack;
    logic [31:0] e_addr, e_wdata, rd;
    @(posedge clk); #1; cyc++;
    if (busy && cyc == a + 1) busy = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (!rq[p] && !infl[p] && int'($urandom_range(99)) < p_req) begin
        rq[p] = 1'b1; ra[p] = $urandom;
        if (p == 1) begin rwe = 1'($urandom_range(1)); rwd = $urandom; end
      end else if (rq[p] && infl[p] && int'($urandom_range(99)) < p_drop) begin
        rq[p] = 1'b0;
      end
    end
    drive();
    ack = 1'b0;
    if (busy && L < T && cyc == g + 1 + L) ack = 1'b1;
    else if (!(busy && cyc >= g + 1 && cyc <= g + W) && int'($urandom_range(99)) < p_spur) ack = 1'b1;
    rd = use_rd ? rd_val : $urandom;
    if (busy && L < T && cyc == g + 1 + L) cap = rd;
    bus.mem_ack_i = ack; bus.mem_rdata_i = rd;

    e_req  = busy && cyc >= g + 1 && cyc <= g + W;
    e_iack = busy && cyc == a && gp == 0;
    e_dack = busy && cyc == a && gp == 1;
    e_err  = busy && cyc == a && perr;
    if (e_iack) m_rd[0] = perr ? 32'd0 : cap;
    if (e_dack && !m_we) m_rd[1] = perr ? 32'd0 : cap;
    e_stall = (rq[0] && !e_iack) || (rq[1] && !e_dack);
    e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;

    if (!busy && (rq[0] || rq[1])) begin
      gp = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
      last = gp; busy = 1'b1; g = cyc; infl[gp] = 1'b1;
      if (force_l >= 0) L = force_l;
      else case ($urandom_range(9))
        0, 1, 2, 3, 4: L = int'($urandom_range(2));
        5, 6:          L = int'($urandom_range(T - 2, 3));
        7:             L = T - 1;
        default:       L = T + 3;
      endcase
      W = (L < T) ? L + 1 : T;
      perr = (L >= T);
      a = g + W + 1;
      m_we    = (gp == 1) ? rwe : 1'b0;
      m_addr  = ra[gp];
      m_wdata = (gp == 1) ? rwd : 32'd0;
    end

    @(negedge clk);
    chk("mem_req",   bus.mem_req_o,   e_req);
    chk("i_ack",     bus.i_ack_o,     e_iack);
    chk("d_ack",     bus.d_ack_o,     e_dack);
    chk("err",       bus.err_o,       e_err);
    chk("stall",     bus.stall_o,     e_stall);
    chk("mem_we",    bus.mem_we_o,    e_we);
    chk("mem_addr",  bus.mem_addr_o,  e_addr);
    chk("mem_wdata", bus.mem_wdata_o, e_wdata);
    chk("i_rdata",   bus.i_rdata_o,   m_rd[0]);
    chk("d_rdata",   bus.d_rdata_o,   m_rd[1]);
    if (e_iack) begin infl[0] = 1'b0; rq[0] = 1'b0; end
    if (e_dack) begin infl[1] = 1'b0; rq[1] = 1'b0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    p_req = 0; p_drop = 0; p_spur = 0; force_l = -1; use_rd = 1'b0; rd_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Single fetch, memory answers two cycles after the request appears
    force_l = 2; use_rd = 1'b1; rd_val = 32'h0051_3093;
    rq[0] = 1'b1; ra[0] = 32'h0000_0010;
    repeat (6) step();
    chk("fetch_rdata", bus.i_rdata_o, 32'h0051_3093);
    use_rd = 1'b0;

    // Both ports from reset: data store first, then alternate; zero-wait, back-to-back
    do_reset(1'b0);
    force_l = 0; p_req = 100;
    rq[0] = 1'b1; ra[0] = 32'h0000_0010;
    rq[1] = 1'b1; ra[1] = 32'h0000_0100; rwe = 1'b1; rwd = 32'hDEAD_BEEF;
    step();
    step();
    chk("tie_first_we",    bus.mem_we_o,    32'd1);
    chk("tie_first_addr",  bus.mem_addr_o,  32'h0000_0100);
    chk("tie_first_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    repeat (16) step();

    // Memory never answers: abort after T wait cycles with err
    do_reset(1'b0);
    p_req = 0; force_l = T + 3;
    rq[0] = 1'b1; ra[0] = 32'h0000_0040;
    repeat (T + 4) step();
    // Ack lands on the expiring cycle: normal load completion
    force_l = T - 1;
    rq[1] = 1'b1; ra[1] = 32'h0000_0080; rwe = 1'b0;
    repeat (T + 4) step();

    // Reset in the middle of a data wait, then the load is reissued
    force_l = 6;
    rq[1] = 1'b1; ra[1] = 32'h0000_0200; rwe = 1'b0;
    repeat (3) step();
    do_reset(1'b1);
    repeat (3) step();
    force_l = 1;
    rq[1] = 1'b1; ra[1] = 32'h0000_0200; rwe = 1'b0;
    repeat (5) step();

    // Random traffic with drops, spurious acks, mixed latencies and timeouts
    force_l = -1; p_req = 35; p_drop = 5; p_spur = 15;
    repeat (1500) step();
    do_reset(1'b1);
    repeat (1500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
